// File: rtl/weapons_pkg.sv
// Shared types and constants for the multi-channel weapons bank.
package weapons_pkg;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_RELOAD   = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_MODE = 2'b01,
    ERR_AMMO = 2'b10,
    ERR_BUSY = 2'b11
  } err_code_e;

  localparam logic [3:0] MODE_ATTACK_DEF = 4'b0010;

endpackage

// File: rtl/weapon_channel.sv
// One weapon channel: ammo/cap/rate registers, cooldown timer and READY/COOLDOWN/RELOAD FSM.
module weapon_channel
  import weapons_pkg::*;
#(
  parameter int unsigned     W           = 9,
  parameter logic [W-1:0]    CAP_RST     = W'(300),
  parameter int unsigned     COOLDOWN    = 8,
  parameter logic [W-1:0]    RELOAD_STEP = W'(16)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fire_hit,
  input  logic         mode_ok,
  input  logic         reload_req,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_cap,
  input  logic [W-1:0] cfg_rate,
  output logic [W-1:0] ammo,
  output logic         ready,
  output logic         accept_c,
  output logic         busy_c,
  output logic         short_c
);

  localparam int unsigned CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  ch_state_e      state_q, state_d;
  logic [W-1:0]   ammo_q, ammo_d;
  logic [W-1:0]   cap_q, cap_d;
  logic [W-1:0]   rate_q, rate_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   rate_eff;
  logic [W-1:0]   cap_eff;
  logic [W:0]     sum;

  // A programmed rate of zero still costs one round per shot.
  assign rate_eff = (rate_q == '0) ? W'(1) : rate_q;
  assign cap_eff  = cfg_we ? cfg_cap : cap_q;
  assign sum      = {1'b0, ammo_q} + {1'b0, RELOAD_STEP};

  assign ready    = (state_q == ST_READY);
  assign ammo     = ammo_q;
  assign accept_c = fire_hit && mode_ok && ready && (ammo_q >= rate_eff);
  assign busy_c   = fire_hit && mode_ok && !ready;
  assign short_c  = fire_hit && mode_ok && ready && (ammo_q < rate_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_READY;
      ammo_q  <= '0;
      cap_q   <= CAP_RST;
      rate_q  <= W'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ammo_q  <= ammo_d;
      cap_q   <= cap_d;
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority on one channel: config over fire over reload.
  always_comb begin
    state_d = state_q;
    ammo_d  = ammo_q;
    cap_d   = cap_q;
    rate_d  = rate_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_READY: begin
        if (accept_c) begin
          ammo_d  = ammo_q - rate_eff;
          state_d = ST_COOLDOWN;
          cnt_d   = CW'(COOLDOWN - 1);
        end else if (reload_req && (ammo_q < cap_eff)) begin
          state_d = ST_RELOAD;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RELOAD: begin
        if (sum >= {1'b0, cap_eff}) begin
          ammo_d  = cap_eff;
          state_d = ST_READY;
        end else begin
          ammo_d = sum[W-1:0];
        end
      end
      default: state_d = ST_READY;
    endcase

    // Clamp is applied after the shot so a same-cycle shot spends the old rate.
    if (cfg_we) begin
      cap_d  = cfg_cap;
      rate_d = cfg_rate;
      if (ammo_d > cfg_cap) begin
        ammo_d = cfg_cap;
      end
    end
  end

endmodule

// File: rtl/weapons_bank.sv
// NCH-channel weapons bank: demuxes fire/config by select and registers fired/error/err_code.
module weapons_bank
  import weapons_pkg::*;
#(
  parameter int unsigned  NCH         = 4,
  parameter int unsigned  W           = 9,
  parameter logic [W-1:0] CAP_RST     = W'(300),
  parameter int unsigned  COOLDOWN    = 8,
  parameter logic [W-1:0] RELOAD_STEP = W'(16),
  parameter logic [3:0]   MODE_ATTACK = MODE_ATTACK_DEF,
  localparam int unsigned SW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       mode,
  input  logic             fire,
  input  logic [SW-1:0]    fire_sel,
  input  logic [NCH-1:0]   reload_req,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_sel,
  input  logic [W-1:0]     cfg_cap,
  input  logic [W-1:0]     cfg_rate,
  output logic [NCH*W-1:0] ammo_out,
  output logic [NCH-1:0]   ready,
  output logic [NCH-1:0]   fired,
  output logic             error,
  output logic [1:0]       err_code
);

  logic             mode_ok;
  logic [NCH-1:0]   fire_hit;
  logic [NCH-1:0]   cfg_hit;
  logic [NCH-1:0]   accept_c;
  logic [NCH-1:0]   busy_c;
  logic [NCH-1:0]   short_c;
  err_code_e        err_d, err_q;

  assign mode_ok = (mode == MODE_ATTACK);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign fire_hit[i] = fire && (fire_sel == SW'(i));
    assign cfg_hit[i]  = cfg_we && (cfg_sel == SW'(i));

    weapon_channel #(
      .W           (W),
      .CAP_RST     (CAP_RST),
      .COOLDOWN    (COOLDOWN),
      .RELOAD_STEP (RELOAD_STEP)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .fire_hit   (fire_hit[i]),
      .mode_ok    (mode_ok),
      .reload_req (reload_req[i]),
      .cfg_we     (cfg_hit[i]),
      .cfg_cap    (cfg_cap),
      .cfg_rate   (cfg_rate),
      .ammo       (ammo_out[i*W +: W]),
      .ready      (ready[i]),
      .accept_c   (accept_c[i]),
      .busy_c     (busy_c[i]),
      .short_c    (short_c[i])
    );
  end

  // Reject reason in priority order: mode, busy, ammo.
  always_comb begin
    err_d = ERR_NONE;
    if (fire) begin
      if (!mode_ok) begin
        err_d = ERR_MODE;
      end else if (|busy_c) begin
        err_d = ERR_BUSY;
      end else if (|short_c) begin
        err_d = ERR_AMMO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fired <= '0;
      error <= 1'b0;
      err_q <= ERR_NONE;
    end else begin
      fired <= accept_c;
      error <= (err_d != ERR_NONE);
      err_q <= err_d;
    end
  end

  assign err_code = err_q;

endmodule

// File: tb/tb_weapons_bank.sv
// Directed self-checking bench for weapons_bank.
module tb_weapons_bank;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 9;

  logic             clk;
  logic             rst_n;
  logic [3:0]       mode;
  logic             fire;
  logic [1:0]       fire_sel;
  logic [NCH-1:0]   reload_req;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [W-1:0]     cfg_cap;
  logic [W-1:0]     cfg_rate;
  logic [NCH*W-1:0] ammo_out;
  logic [NCH-1:0]   ready;
  logic [NCH-1:0]   fired;
  logic             error;
  logic [1:0]       err_code;

  int errors = 0;
  int checks = 0;

  weapons_bank dut (
    .clk        (clk),
    .rst        (rst_n),
    .mode       (mode),
    .fire       (fire),
    .fire_sel   (fire_sel),
    .reload_req (reload_req),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_cap    (cfg_cap),
    .cfg_rate   (cfg_rate),
    .ammo_out   (ammo_out),
    .ready      (ready),
    .fired      (fired),
    .error      (error),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] am(input int i);
    return 64'(ammo_out[i*W +: W]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 4'b0000; fire = 1'b0; fire_sel = 2'd0; reload_req = '0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_cap = '0; cfg_rate = '0;
    #3;
    chk("rst_ammo",  64'(ammo_out), 64'(0));
    chk("rst_ready", 64'(ready),    64'(4'hF));
    chk("rst_fired", 64'(fired),    64'(0));
    chk("rst_error", 64'(error),    64'(0));
    chk("rst_code",  64'(err_code), 64'(0));
    step(); step();
    rst_n = 1'b1;
    step();

    // ch0 cap=100 rate=10, then reload from empty
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_cap = 9'd100; cfg_rate = 9'd10;
    step();
    cfg_we = 1'b0;
    chk("cfg_ammo0", am(0), 64'(0));
    reload_req = 4'b0001;
    step();
    reload_req = '0;
    chk("rl_enter_ready", 64'(ready[0]), 64'(0));
    chk("rl_enter_ammo",  am(0), 64'(0));
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("rl_ammo",  am(0), (k < 7) ? 64'(16 * k) : 64'(100));
      chk("rl_ready", 64'(ready[0]), (k == 7) ? 64'(1) : 64'(0));
    end

    // accepted shot and cooldown with busy fire at +3
    mode = 4'b0010; fire = 1'b1; fire_sel = 2'd0;
    step();
    fire = 1'b0;
    chk("shot_fired", 64'(fired), 64'(4'b0001));
    chk("shot_ammo",  am(0), 64'(90));
    chk("shot_ready", 64'(ready[0]), 64'(0));
    chk("shot_err",   64'(error), 64'(0));
    step();
    chk("pulse_once", 64'(fired), 64'(0));
    chk("cd1_ready",  64'(ready[0]), 64'(0));
    step();
    fire = 1'b1; fire_sel = 2'd0;
    step();
    fire = 1'b0;
    chk("busy_err",   64'(error), 64'(1));
    chk("busy_code",  64'(err_code), 64'(2'b11));
    chk("busy_fired", 64'(fired), 64'(0));
    chk("busy_ammo",  am(0), 64'(90));
    step();
    chk("err_once", 64'(error), 64'(0));
    step(); step(); step();
    chk("cd7_ready", 64'(ready[0]), 64'(0));
    step();
    chk("cd8_ready", 64'(ready[0]), 64'(1));

    // wrong mode
    mode = 4'b0001; fire = 1'b1; fire_sel = 2'd1;
    step();
    fire = 1'b0;
    chk("mode_err",   64'(error), 64'(1));
    chk("mode_code",  64'(err_code), 64'(2'b01));
    chk("mode_fired", 64'(fired), 64'(0));
    chk("mode_ammo",  64'(ammo_out), 64'(90));
    mode = 4'b0010;

    // ch2 with ammo=5 below rate=10
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_cap = 9'd5; cfg_rate = 9'd10;
    step();
    cfg_we = 1'b0;
    reload_req = 4'b0100;
    step();
    reload_req = '0;
    chk("ch2_rl_ready", 64'(ready[2]), 64'(0));
    step();
    chk("ch2_ammo",  am(2), 64'(5));
    chk("ch2_ready", 64'(ready[2]), 64'(1));
    fire = 1'b1; fire_sel = 2'd2;
    step();
    fire = 1'b0;
    chk("short_err",   64'(error), 64'(1));
    chk("short_code",  64'(err_code), 64'(2'b10));
    chk("short_ammo",  am(2), 64'(5));
    chk("short_fired", 64'(fired), 64'(0));

    // capacity clamp, then shot with simultaneous reload request
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_cap = 9'd50; cfg_rate = 9'd10;
    step();
    cfg_we = 1'b0;
    chk("clamp_ammo", am(0), 64'(50));
    fire = 1'b1; fire_sel = 2'd0; reload_req = 4'b0001;
    step();
    fire = 1'b0; reload_req = '0;
    chk("fr_fired", 64'(fired), 64'(4'b0001));
    chk("fr_ammo",  am(0), 64'(40));
    chk("fr_ready", 64'(ready[0]), 64'(0));
    for (int k = 0; k < 8; k++) step();
    chk("fr_ready_back", 64'(ready[0]), 64'(1));
    step();
    chk("fr_no_reload", am(0), 64'(40));

    // config and shot together: old rate, then clamp
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_cap = 9'd25; cfg_rate = 9'd3;
    fire = 1'b1; fire_sel = 2'd0;
    step();
    cfg_we = 1'b0; fire = 1'b0;
    chk("cf_fired", 64'(fired), 64'(4'b0001));
    chk("cf_ammo",  am(0), 64'(25));
    for (int k = 0; k < 8; k++) step();

    // zero rate still spends one round
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_cap = 9'd25; cfg_rate = 9'd0;
    step();
    cfg_we = 1'b0;
    fire = 1'b1; fire_sel = 2'd0;
    step();
    fire = 1'b0;
    chk("r0_fired", 64'(fired), 64'(4'b0001));
    chk("r0_ammo",  am(0), 64'(24));
    for (int k = 0; k < 8; k++) step();

    // reset in the middle of a ch3 reload with an error pulse live
    reload_req = 4'b1000;
    step();
    reload_req = '0;
    chk("ch3_rl_ready", 64'(ready[3]), 64'(0));
    step();
    chk("ch3_ammo16", am(3), 64'(16));
    mode = 4'b0001; fire = 1'b1; fire_sel = 2'd3;
    step();
    fire = 1'b0;
    chk("pre_rst_err", 64'(error), 64'(1));
    chk("ch3_ammo32",  am(3), 64'(32));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ammo",  64'(ammo_out), 64'(0));
    chk("mrst_ready", 64'(ready), 64'(4'hF));
    chk("mrst_error", 64'(error), 64'(0));
    chk("mrst_fired", 64'(fired), 64'(0));
    chk("mrst_code",  64'(err_code), 64'(0));
    step();
    rst_n = 1'b1; mode = 4'b0010;
    step();

    // capacity back to 300 after reset: full reload takes 19 cycles
    reload_req = 4'b1000;
    step();
    reload_req = '0;
    for (int k = 0; k < 18; k++) step();
    chk("cap_ammo288",  am(3), 64'(288));
    chk("cap_ready288", 64'(ready[3]), 64'(0));
    step();
    chk("cap_ammo300",  am(3), 64'(300));
    chk("cap_ready300", 64'(ready[3]), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weapons_bank.md
Name: weapons_bank

Overview:
- Multi-channel successor to the single-counter weapons controller. Manages NCH independent weapon channels.
- Each channel has a saturating ammo counter, a programmable capacity and per-shot rate, a post-shot cooldown timer, and a timed reload sequence.
- Fire requests are gated by ship mode (attack = 4'b0010). Every rejected request produces a one-cycle error pulse with a reason code.
- Sits between the command decoder (mode, fire, reload, config writes) and the HUD/status logic (ammo, ready, fired, error).

Parameters:
- NCH, 4, number of weapon channels (>=1)
- W, 9, ammo counter / capacity / rate width
- CAP_RST, 9'd300, capacity value loaded at reset
- COOLDOWN, 8, cycles a channel is busy after an accepted shot (>=1)
- RELOAD_STEP, 9'd16, ammo added per cycle while reloading
- MODE_ATTACK, 4'b0010, mode encoding that permits firing

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  4  current ship mode
- fire  in  1  fire request, sampled every cycle
- fire_sel  in  $clog2(NCH)  channel targeted by fire
- reload_req  in  NCH  per-channel reload request
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  $clog2(NCH)  channel targeted by cfg_we
- cfg_cap  in  W  new capacity
- cfg_rate  in  W  new ammo cost per shot
- ammo_out  out  NCH*W  per-channel ammo; channel i occupies bits [i*W +: W]
- ready  out  NCH  1 = channel in READY state
- fired  out  NCH  one-cycle pulse, channel shot accepted
- error  out  1  one-cycle pulse, fire request rejected
- err_code  out  2  reason, valid when error=1: 01 wrong mode, 10 insufficient ammo, 11 channel busy

Behaviour:
- Reset (rst=0, asynchronous):
  - all ammo=0, cap=CAP_RST, rate=1, state=READY
  - fired=0, error=0, err_code=0
- Per-channel FSM:
  - READY -> COOLDOWN on an accepted shot; cooldown counter loads COOLDOWN-1.
  - COOLDOWN: counter decrements each cycle; returns to READY the cycle after it reads 0. The channel is therefore busy for exactly COOLDOWN cycles.
  - READY -> RELOAD when reload_req[i]=1 and ammo<cap. If ammo==cap the request is ignored and no error is raised.
  - reload_req in COOLDOWN or RELOAD is ignored.
  - RELOAD: each cycle ammo = min(ammo+RELOAD_STEP, cap), computed at W+1 bits, no wrap. Returns to READY in the cycle ammo reaches cap.
- Fire evaluation (fire=1, channel c=fire_sel), checked in priority order:
  1. mode!=MODE_ATTACK -> reject, code 01
  2. state!=READY -> reject, code 11
  3. ammo<rate -> reject, code 10; no partial shot, ammo unchanged
  4. otherwise accept: ammo -= rate, fired[c]=1 next cycle, channel enters COOLDOWN
- Output timing: error, err_code and fired are registered, asserting one cycle after the fire sample and lasting exactly one cycle. Back-to-back fire cycles evaluate independently.
- Effective rate: a rate register value of 0 is treated as 1, so ammo always decreases on a shot.
- Config write (cfg_we=1):
  - cap[cfg_sel] and rate[cfg_sel] update at the edge.
  - If ammo > cfg_cap, ammo clamps to cfg_cap at the same edge.
  - A channel in RELOAD whose ammo is now >= the new cap exits to READY.
- Same-cycle conflicts on one channel, priority cfg > fire > reload:
  - Shot accepted and reload_req in the same cycle: the reload is dropped.
  - cfg_we and an accepted fire in the same cycle: the shot uses the old rate, then the clamp is applied to the result.
- Ammo never exceeds cap and never underflows.
- Reset mid-cooldown or mid-reload returns the channel to the reset values immediately.

Decomposition:
- Shared package weapons_pkg:
  - state encoding (READY=2'd0, COOLDOWN=2'd1, RELOAD=2'd2)
  - error codes (ERR_NONE, ERR_MODE, ERR_AMMO, ERR_BUSY)
  - MODE_ATTACK constant
- Sub-module weapon_channel: holds one channel's ammo, cap, rate, cooldown counter and FSM. Outputs accept/reject flags for its fire strobe.
- weapons_bank generates NCH instances, demuxes fire/cfg by select, and registers fired, error and err_code.

Test Plan:
- Reset then cfg ch0 cap=100 rate=10; reload_req[0] -> RELOAD for 7 cycles, ammo 16,32,...,96,100, then ready[0]=1.
- mode=0010, fire ch0 with ammo=100 -> fired[0] pulse next cycle, ammo=90, ready[0]=0 for 8 cycles. A fire at cycle +3 -> error with code 11.
- mode=0001, fire ch1 -> error with code 01, ammo_out unchanged, fired=0.
- ch2 ammo=5, rate=10, mode=0010, fire -> error with code 10, ammo stays 5.
- ch0 ammo=90, cfg cap=50 -> ammo=50 at the same edge. Accepted fire together with reload_req[0] -> ammo=40, no reload.
- Assert rst=0 mid-RELOAD on ch3 -> ammo=0, cap=300, ready=1 immediately, error=0, fired=0.
